// File: rtl/pu_ctrl.sv
// pu_ctrl: sequencer for one processing-unit job.
//
// A job is num_out outputs accumulated over num_pass partial-sum passes.
// Each accepted operand (out_data_req & in_data_valid) issues one op:
//   o runs 0..num_out-1 (inner loop) and p runs 0..num_pass-1 (outer loop).
// The op reads weight w_base + p*num_out + o and cache line o.
// MAC_LAT cycles after issue, the partial sum is written back to cache line o.
// Ops on the last pass also write result r_base + o in that same cycle.
//
// Handshake: an operand is consumed on every rising edge where out_data_req
// and in_data_valid are both high. in_data_valid may drop at any time. While
// it is low, the op counters and the PU operand outputs hold their values. The
// writeback pipeline keeps moving regardless.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_start          launch a job (sampled only in IDLE) together with
//                     in_num_out, in_num_pass, in_w_base, in_r_base,
//                     in_add_bias, in_relu, in_bias_addr
//   in_data_valid     activation operand available
//   out_busy          high in every state except IDLE
//   out_job_done      one-cycle completion pulse
//   out_data_req      high during RUN; consumes an operand with in_data_valid
//   out_w_rd_addr, out_cache_rd_addr, out_done, out_add_bias, out_relu,
//   out_bias_addr     PU operand side
//   out_cache_clear   one-cycle cache clear at job start
//   out_cache_wr_en/addr, out_r_wr_en/addr   writeback side
//   dbg_state         current FSM state (IDLE=0 CLEAR=1 RUN=2 DRAIN=3 FIN=4)
module pu_ctrl #(
  parameter int WADDR_WIDTH = 7,
  parameter int RADDR_WIDTH = 6,
  parameter int MAC_LAT     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_start,
  input  logic [5:0]             in_num_out,
  input  logic [7:0]             in_num_pass,
  input  logic [WADDR_WIDTH-1:0] in_w_base,
  input  logic [RADDR_WIDTH-1:0] in_r_base,
  input  logic                   in_add_bias,
  input  logic                   in_relu,
  input  logic [2:0]             in_bias_addr,
  input  logic                   in_data_valid,
  output logic                   out_busy,
  output logic                   out_job_done,
  output logic                   out_data_req,
  output logic [WADDR_WIDTH-1:0] out_w_rd_addr,
  output logic [2:0]             out_bias_addr,
  output logic                   out_cache_clear,
  output logic [4:0]             out_cache_rd_addr,
  output logic                   out_cache_wr_en,
  output logic [4:0]             out_cache_wr_addr,
  output logic                   out_add_bias,
  output logic                   out_relu,
  output logic                   out_done,
  output logic                   out_r_wr_en,
  output logic [RADDR_WIDTH-1:0] out_r_wr_addr,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // The last pipeline stage is the writeback cycle itself. DRAIN may leave
  // once only that stage (or nothing) is occupied, so FIN follows the final
  // writeback directly.
  localparam logic [MAC_LAT-1:0] DRAIN_MASK = {MAC_LAT{1'b1}} >> 1;

  state_t state, state_nxt;

  // Latched job configuration
  logic [5:0]             num_out_q;
  logic [7:0]             num_pass_q;
  logic [RADDR_WIDTH-1:0] r_base_q;
  logic                   add_bias_q;
  logic                   relu_q;
  logic [2:0]             bias_addr_q;
  logic                   cfg_ok_q;

  // Op counters; w_addr_q tracks w_base + p*num_out + o incrementally
  logic [4:0]             o_cnt;
  logic [7:0]             p_cnt;
  logic [WADDR_WIDTH-1:0] w_addr_q;

  // Writeback pipeline, stage 0 loaded by the issuing edge
  logic [MAC_LAT-1:0]     pipe_v;
  logic [MAC_LAT-1:0]     pipe_last;
  logic [4:0]             pipe_o [MAC_LAT];

  logic [5:0] num_out_clamped;
  logic       zero_cfg;
  logic       start_ok;
  logic       fire;
  logic       o_last;
  logic       p_last;
  logic       op_last;

  assign num_out_clamped = (in_num_out > 6'd32) ? 6'd32 : in_num_out;
  assign zero_cfg        = (in_num_out == 6'd0) || (in_num_pass == 8'd0);
  assign start_ok        = (state == S_IDLE) && in_start;
  assign fire            = (state == S_RUN) && in_data_valid;
  assign o_last          = ({1'b0, o_cnt} == (num_out_q - 6'd1));
  assign p_last          = cfg_ok_q && (p_cnt == (num_pass_q - 8'd1));
  assign op_last         = o_last && p_last;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_start) state_nxt = zero_cfg ? S_FIN : S_CLEAR;
      S_CLEAR: state_nxt = S_RUN;
      S_RUN:   if (fire && op_last) state_nxt = S_DRAIN;
      S_DRAIN: if ((pipe_v & DRAIN_MASK) == '0) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, configuration and op counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      num_out_q   <= '0;
      num_pass_q  <= '0;
      r_base_q    <= '0;
      add_bias_q  <= 1'b0;
      relu_q      <= 1'b0;
      bias_addr_q <= '0;
      cfg_ok_q    <= 1'b0;
      o_cnt       <= '0;
      p_cnt       <= '0;
      w_addr_q    <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        num_out_q   <= num_out_clamped;
        num_pass_q  <= in_num_pass;
        r_base_q    <= in_r_base;
        add_bias_q  <= in_add_bias;
        relu_q      <= in_relu;
        bias_addr_q <= in_bias_addr;
        cfg_ok_q    <= !zero_cfg;
        o_cnt       <= '0;
        p_cnt       <= '0;
        w_addr_q    <= in_w_base;
      end else if (fire && !op_last) begin
        // The final op leaves the counters parked so the operand outputs
        // keep showing it through DRAIN.
        w_addr_q <= w_addr_q + WADDR_WIDTH'(1);
        if (o_last) begin
          o_cnt <= '0;
          p_cnt <= p_cnt + 8'd1;
        end else begin
          o_cnt <= o_cnt + 5'd1;
        end
      end
    end
  end

  // Writeback pipeline: shifts every cycle, stalls only inject bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v    <= '0;
      pipe_last <= '0;
      for (int i = 0; i < MAC_LAT; i++) pipe_o[i] <= '0;
    end else begin
      pipe_v[0]    <= fire;
      pipe_last[0] <= fire && p_last;
      pipe_o[0]    <= fire ? o_cnt : 5'd0;
      for (int i = 1; i < MAC_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_o[i]    <= pipe_o[i-1];
      end
    end
  end

  // Outputs are forced low while rst is high so that no write can escape in
  // the cycle reset is first applied.
  always_comb begin
    out_busy          = 1'b0;
    out_job_done      = 1'b0;
    out_data_req      = 1'b0;
    out_w_rd_addr     = '0;
    out_bias_addr     = '0;
    out_cache_clear   = 1'b0;
    out_cache_rd_addr = '0;
    out_cache_wr_en   = 1'b0;
    out_cache_wr_addr = '0;
    out_add_bias      = 1'b0;
    out_relu          = 1'b0;
    out_done          = 1'b0;
    out_r_wr_en       = 1'b0;
    out_r_wr_addr     = '0;
    if (!rst) begin
      out_busy          = (state != S_IDLE);
      out_job_done      = (state == S_FIN);
      out_data_req      = (state == S_RUN);
      out_cache_clear   = (state == S_CLEAR);
      out_w_rd_addr     = w_addr_q;
      out_bias_addr     = bias_addr_q;
      out_cache_rd_addr = o_cnt;
      out_done          = p_last;
      out_add_bias      = p_last && add_bias_q;
      out_relu          = p_last && relu_q;
      out_cache_wr_en   = pipe_v[MAC_LAT-1];
      out_cache_wr_addr = pipe_o[MAC_LAT-1];
      out_r_wr_en       = pipe_v[MAC_LAT-1] && pipe_last[MAC_LAT-1];
      if (out_r_wr_en) out_r_wr_addr = r_base_q + RADDR_WIDTH'(pipe_o[MAC_LAT-1]);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pu_ctrl.sv
// Testbench for pu_ctrl. A job-level model (op index k, and a queue of
// writebacks with due cycles) predicts every output on every cycle. Directed
// jobs add literal checks on logged address sequences and timing.
module tb_pu_ctrl;
  localparam int WA = 7;
  localparam int RA = 6;
  localparam int ML = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_start = 0;
  logic [5:0]    in_num_out = 0;
  logic [7:0]    in_num_pass = 0;
  logic [WA-1:0] in_w_base = 0;
  logic [RA-1:0] in_r_base = 0;
  logic          in_add_bias = 0;
  logic          in_relu = 0;
  logic [2:0]    in_bias_addr = 0;
  logic          in_data_valid = 0;

  logic          out_busy, out_job_done, out_data_req;
  logic [WA-1:0] out_w_rd_addr;
  logic [2:0]    out_bias_addr;
  logic          out_cache_clear;
  logic [4:0]    out_cache_rd_addr;
  logic          out_cache_wr_en;
  logic [4:0]    out_cache_wr_addr;
  logic          out_add_bias, out_relu, out_done, out_r_wr_en;
  logic [RA-1:0] out_r_wr_addr;
  logic [2:0]    dbg_state;

  pu_ctrl #(.WADDR_WIDTH(WA), .RADDR_WIDTH(RA), .MAC_LAT(ML)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_num_out(in_num_out),
    .in_num_pass(in_num_pass), .in_w_base(in_w_base), .in_r_base(in_r_base),
    .in_add_bias(in_add_bias), .in_relu(in_relu), .in_bias_addr(in_bias_addr),
    .in_data_valid(in_data_valid), .out_busy(out_busy),
    .out_job_done(out_job_done), .out_data_req(out_data_req),
    .out_w_rd_addr(out_w_rd_addr), .out_bias_addr(out_bias_addr),
    .out_cache_clear(out_cache_clear), .out_cache_rd_addr(out_cache_rd_addr),
    .out_cache_wr_en(out_cache_wr_en), .out_cache_wr_addr(out_cache_wr_addr),
    .out_add_bias(out_add_bias), .out_relu(out_relu), .out_done(out_done),
    .out_r_wr_en(out_r_wr_en), .out_r_wr_addr(out_r_wr_addr),
    .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_RUN = 2, PH_DRAIN = 3, PH_FIN = 4;

  typedef struct {
    int due;
    int o;
    bit last;
  } wb_t;

  wb_t exp_q[$];
  int  m_phase = PH_IDLE;
  int  m_no = 0, m_np = 0, m_wb = 0, m_rb = 0, m_ab = 0, m_rl = 0, m_ba = 0;
  bit  m_ok = 0;
  int  m_k = 0, m_tlast = 0;
  int  cyc = 0;
  bit  live = 0;

  always @(posedge clk) begin : model_step
    wb_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
    if (rst) begin
      m_phase = PH_IDLE;
      m_no = 0; m_np = 0; m_wb = 0; m_rb = 0; m_ab = 0; m_rl = 0; m_ba = 0;
      m_ok = 0; m_k = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        PH_IDLE: if (in_start) begin
          m_no = (in_num_out > 32) ? 32 : int'(in_num_out);
          m_np = in_num_pass; m_wb = in_w_base; m_rb = in_r_base;
          m_ab = in_add_bias; m_rl = in_relu; m_ba = in_bias_addr;
          m_k = 0;
          m_ok = (m_no != 0) && (m_np != 0);
          m_phase = m_ok ? PH_CLEAR : PH_FIN;
        end
        PH_CLEAR: m_phase = PH_RUN;
        PH_RUN: if (in_data_valid) begin
          e.due = cyc + ML;
          e.o = m_k % m_no;
          e.last = (m_k / m_no == m_np - 1);
          exp_q.push_back(e);
          if (m_k == m_no * m_np - 1) begin
            m_phase = PH_DRAIN;
            m_tlast = cyc;
          end else m_k++;
        end
        PH_DRAIN: if (cyc == m_tlast + ML) m_phase = PH_FIN;
        PH_FIN: m_phase = PH_IDLE;
        default: m_phase = PH_IDLE;
      endcase
    end
    cyc++;
    live = 1;
  end

  // ---------------- logs for literal checks ----------------
  int w_log[$];
  int d_log[$];
  int r_log[$];
  int n_cwr = 0, n_clr = 0, n_req = 0, t_done = -1, t_start = 0;

  task automatic clear_logs();
    w_log.delete(); d_log.delete(); r_log.delete();
    n_cwr = 0; n_clr = 0; n_req = 0; t_done = -1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    bit e_wr, e_done, e_act;
    int e_o;
    if (live) begin
      e_act  = !rst;
      e_wr   = e_act && exp_q.size() > 0 && exp_q[0].due == cyc;
      e_o    = e_wr ? exp_q[0].o : 0;
      e_done = e_act && m_ok && (m_k / m_no == m_np - 1);
      chk("busy",      out_busy,        e_act && m_phase != PH_IDLE);
      chk("data_req",  out_data_req,    e_act && m_phase == PH_RUN);
      chk("clear",     out_cache_clear, e_act && m_phase == PH_CLEAR);
      chk("job_done",  out_job_done,    e_act && m_phase == PH_FIN);
      chk("w_rd_addr", out_w_rd_addr,   e_act ? (m_wb + m_k) % (1 << WA) : 0);
      chk("cache_rd",  out_cache_rd_addr, (e_act && m_no > 0) ? m_k % m_no : 0);
      chk("bias_addr", out_bias_addr,   e_act ? m_ba : 0);
      chk("done",      out_done,        e_done);
      chk("add_bias",  out_add_bias,    e_done && m_ab != 0);
      chk("relu",      out_relu,        e_done && m_rl != 0);
      chk("cache_wr_en", out_cache_wr_en, e_wr);
      chk("r_wr_en",   out_r_wr_en,     e_wr && exp_q[0].last);
      if (e_wr) begin
        chk("cache_wr_addr", out_cache_wr_addr, e_o);
        if (exp_q[0].last) chk("r_wr_addr", out_r_wr_addr, (m_rb + e_o) % (1 << RA));
      end
      if (out_data_req && in_data_valid) begin
        w_log.push_back(out_w_rd_addr);
        d_log.push_back(out_done);
      end
      if (out_cache_wr_en) n_cwr++;
      if (out_r_wr_en) r_log.push_back(out_r_wr_addr);
      if (out_cache_clear) n_clr++;
      if (out_data_req) n_req++;
      if (out_job_done) t_done = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vmode 0: valid held high; vmode 1: valid toggles every cycle.
  // inject_at >= 0 pulses in_start with a different config mid-job.
  task automatic run_job(input int no, input int np, input int wb, input int rb,
                         input int ab, input int rl, input int ba,
                         input int vmode, input int inject_at);
    int n;
    clear_logs();
    in_num_out = 6'(no); in_num_pass = 8'(np); in_w_base = WA'(wb);
    in_r_base = RA'(rb); in_add_bias = ab[0]; in_relu = rl[0];
    in_bias_addr = 3'(ba);
    in_start = 1; in_data_valid = 0;
    t_start = cyc;
    tick();
    in_start = 0;
    n = 0;
    while (out_busy && n < 200) begin
      in_data_valid = (vmode == 0) ? 1'b1 : (n % 2 == 0);
      if (n == inject_at) begin
        in_start = 1; in_num_out = 6'd7; in_num_pass = 8'd5;
        in_w_base = WA'(99); in_r_base = RA'(33); in_bias_addr = 3'd6;
      end else in_start = 0;
      tick();
      n++;
    end
    in_start = 0;
    in_data_valid = 0;
    if (n >= 200) chk("job_timeout", out_busy, 0);
    tick();
  endtask

  task automatic chk_seq(input string name, input int got[$], input int base, input int cnt, input int modv);
    chk({name, "_len"}, got.size(), cnt);
    for (int i = 0; i < got.size() && i < cnt; i++) chk(name, got[i], (base + i) % modv);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_state_idle"}, dbg_state, 0);
    chk({tag, "_busy"}, out_busy, 0);
    chk({tag, "_req"}, out_data_req, 0);
    chk({tag, "_jd"}, out_job_done, 0);
    chk({tag, "_w"}, out_w_rd_addr, 0);
    chk({tag, "_crd"}, out_cache_rd_addr, 0);
    chk({tag, "_cwe"}, out_cache_wr_en, 0);
    chk({tag, "_cwa"}, out_cache_wr_addr, 0);
    chk({tag, "_rwe"}, out_r_wr_en, 0);
    chk({tag, "_rwa"}, out_r_wr_addr, 0);
    chk({tag, "_done"}, out_done, 0);
    chk({tag, "_ba"}, out_bias_addr, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick(); tick();
    chk_zero_outputs("rst_hold");
    rst = 0;
    tick();
    chk_zero_outputs("post_rst");

    // 4 outputs x 2 passes, valid held high
    run_job(4, 2, 10, 5, 1, 1, 3, 0, -1);
    chk_seq("A_w", w_log, 10, 8, 1 << WA);
    for (int i = 0; i < d_log.size(); i++) chk("A_done", d_log[i], (i >= 4) ? 1 : 0);
    chk_seq("A_r", r_log, 5, 4, 1 << RA);
    chk("A_latency", t_done - t_start, 13);
    chk("A_clear", n_clr, 1);
    chk("A_cwr", n_cwr, 8);

    // same job with valid toggling
    run_job(4, 2, 10, 5, 0, 1, 5, 1, -1);
    chk_seq("B_w", w_log, 10, 8, 1 << WA);
    chk_seq("B_r", r_log, 5, 4, 1 << RA);
    chk("B_cwr", n_cwr, 8);

    // address wrap on both memories
    run_job(4, 1, 126, 63, 1, 0, 2, 0, -1);
    w_log.push_front(0); void'(w_log.pop_front());
    chk("C_len", w_log.size(), 4);
    if (w_log.size() == 4) begin
      chk("C_w0", w_log[0], 126); chk("C_w1", w_log[1], 127);
      chk("C_w2", w_log[2], 0);   chk("C_w3", w_log[3], 1);
    end
    chk("C_rlen", r_log.size(), 4);
    if (r_log.size() == 4) begin
      chk("C_r0", r_log[0], 63); chk("C_r1", r_log[1], 0);
      chk("C_r2", r_log[2], 1);  chk("C_r3", r_log[3], 2);
    end

    // zero passes and zero outputs: straight to FIN
    run_job(4, 0, 20, 3, 1, 1, 1, 0, -1);
    chk("D_latency", t_done - t_start, 1);
    chk("D_clear", n_clr, 0);
    chk("D_req", n_req, 0);
    chk("D_cwr", n_cwr, 0);
    chk("D_rwr", r_log.size(), 0);
    run_job(0, 3, 20, 3, 0, 0, 0, 0, -1);
    chk("D2_latency", t_done - t_start, 1);
    chk("D2_req", n_req, 0);

    // num_out above 32 clamps to 32
    run_job(40, 1, 0, 0, 0, 1, 7, 0, -1);
    chk("E_fires", w_log.size(), 32);
    chk("E_cwr", n_cwr, 32);
    chk("E_rlen", r_log.size(), 32);
    if (r_log.size() == 32) chk("E_rlast", r_log[31], 31);

    // start pulse with other config mid-job is ignored
    run_job(4, 2, 10, 5, 1, 0, 4, 0, 3);
    chk_seq("G_w", w_log, 10, 8, 1 << WA);
    chk_seq("G_r", r_log, 5, 4, 1 << RA);
    chk("G_latency", t_done - t_start, 13);

    // reset during RUN with writebacks in flight
    clear_logs();
    in_num_out = 6'd4; in_num_pass = 8'd2; in_w_base = WA'(10); in_r_base = RA'(5);
    in_add_bias = 1; in_relu = 1; in_bias_addr = 3'd5;
    in_start = 1; tick(); in_start = 0;
    in_data_valid = 1;
    repeat (6) tick();
    chk("F_mid_busy", out_busy, 1);
    rst = 1;
    tick();
    chk_zero_outputs("F_rst");
    n_cwr = 0; r_log.delete();
    tick();
    rst = 0;
    repeat (6) tick();
    in_data_valid = 0;
    chk("F_no_cwr", n_cwr, 0);
    chk("F_no_rwr", r_log.size(), 0);
    chk("F_idle", out_busy, 0);

    // a normal job still runs after the mid-job reset
    run_job(3, 1, 50, 10, 1, 1, 2, 1, -1);
    chk_seq("H_w", w_log, 50, 3, 1 << WA);
    chk_seq("H_r", r_log, 10, 3, 1 << RA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pu_ctrl.md
PU_CTRL -- requirements
Module: pu_ctrl

Interface
REQ-001 SHALL have parameter WADDR_WIDTH, default 7, meaning weight-memory address width.
REQ-002 SHALL have parameter RADDR_WIDTH, default 6, meaning result-memory address width.
REQ-003 SHALL have parameter MAC_LAT, default 3, meaning the number of cycles from operand issue to PU partial-sum writeback (range 1..8).
REQ-004 Ports: clk  in  1  clock; the block SHALL use one clock, and all state SHALL update on its rising edge.
REQ-005 Ports: rst  in  1  reset; reset SHALL be synchronous and active-high.
REQ-006 in_start in 1 (launch job); in_num_out in 6 (outputs per pass, 1..32); in_num_pass in 8 (partial-sum passes, 1..255); in_w_base in WADDR_WIDTH; in_r_base in RADDR_WIDTH; in_add_bias in 1; in_relu in 1; in_bias_addr in 3; in_data_valid in 1 (activation operand available).
REQ-007 out_busy out 1; out_job_done out 1 (one-cycle pulse); out_data_req out 1 (operand consumed when high with in_data_valid).
REQ-008 To PU: out_w_rd_addr out WADDR_WIDTH; out_bias_addr out 3; out_cache_clear out 1; out_cache_rd_addr out 5; out_cache_wr_en out 1; out_cache_wr_addr out 5; out_add_bias out 1; out_relu out 1; out_done out 1; out_r_wr_en out 1; out_r_wr_addr out RADDR_WIDTH.

Function
REQ-009 States SHALL be IDLE, CLEAR, RUN, DRAIN, FIN.
REQ-010 IDLE: on in_start=1, SHALL latch all in_* config and go to CLEAR; if the latched num_out=0 or num_pass=0, SHALL go directly to FIN with no memory activity.
REQ-011 A num_out value above 32 SHALL be clamped to 32.
REQ-012 CLEAR SHALL last exactly one cycle with out_cache_clear=1, then go to RUN.
REQ-013 RUN: out_data_req=1; fire = out_data_req & in_data_valid; exactly one op SHALL issue per fire cycle.
REQ-014 Each op SHALL use counters o (0..num_out-1, inner) and p (0..num_pass-1, outer), with out_cache_rd_addr=o and out_w_rd_addr=w_base+p*num_out+o, modulo 2^WADDR_WIDTH.
REQ-015 When not firing, counters SHALL hold and the PU operand outputs SHALL hold their last values.
REQ-016 out_done, out_add_bias (latched add_bias) and out_relu (latched relu) SHALL be 1 only while p=num_pass-1, and 0 otherwise; out_bias_addr SHALL equal the latched value throughout the job.
REQ-017 When the op with o=num_out-1, p=num_pass-1 fires, the FSM SHALL go to DRAIN and drop out_data_req the next cycle.
REQ-018 Writeback SHALL be a MAC_LAT-deep shift pipeline: out_cache_wr_en=1 with out_cache_wr_addr=o exactly MAC_LAT cycles after each fire, and only then.
REQ-019 For last-pass ops, out_r_wr_en=1 with out_r_wr_addr=r_base+o (modulo 2^RADDR_WIDTH) SHALL occur in the same writeback cycle.
REQ-020 The writeback pipeline SHALL advance every cycle regardless of stalls.
REQ-021 DRAIN SHALL stay until the pipeline is empty (MAC_LAT cycles after the final fire), then go to FIN.
REQ-022 FIN SHALL pulse out_job_done=1 for one cycle, then go to IDLE.
REQ-023 out_busy SHALL be 1 in every state except IDLE.
REQ-024 in_start SHALL be ignored when not in IDLE; config inputs SHALL be sampled only at start acceptance.
REQ-025 Counters SHALL use widths p:8 and o:5, with no overflow for the legal ranges.

Reset
REQ-026 When rst=1, the block SHALL go to IDLE, clear counters, and flush the writeback pipeline, including mid-job; no cache or result write SHALL issue after reset is asserted.
REQ-027 During and after reset, all outputs SHALL be 0 (addresses 0, out_busy=0, out_data_req=0, out_job_done=0).

Verification
REQ-028 Scenario: num_out=4, num_pass=2, w_base=10, r_base=5, in_data_valid held 1, MAC_LAT=3 -> SHALL produce one cache_clear cycle, then w_rd_addr 10..17 on consecutive cycles, out_done high for the last 4, r_wr_addr 5,6,7,8 three cycles after each, and out_job_done 13 cycles after start acceptance.
REQ-029 Scenario: the same job with in_data_valid toggling 1,0,1,0 -> SHALL give addresses unchanged across stall cycles, 8 cache writes total, 4 result writes, and correct ordering.
REQ-030 Scenario: w_base=126, num_out=4, num_pass=1 -> SHALL give w_rd_addr 126,127,0,1; r_base=63 -> SHALL give r_wr_addr 63,0,1,2.
REQ-031 Scenario: num_pass=0 -> SHALL give out_job_done the cycle after FIN entry, with no cache_clear, data_req, or writes; num_out=40 -> SHALL run as 32.
REQ-032 Scenario: rst asserted during RUN with writebacks in flight -> the next cycle SHALL show IDLE, all outputs 0, and no further write enables.
REQ-033 Scenario: in_start pulsed during RUN with different config -> SHALL be ignored, and the original job SHALL complete unchanged.
